// File: rtl/riscv_pkg.sv
// Shared RISC-V trace types: record layout, packet constants and the record-to-packet packer.
// Memory fields exist only when RISCV_TRACE_MEM_EN is defined.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0] TRACE_HDR_SYNC = 8'h80;
  localparam int TRACE_LEN_BASE = 14;
  localparam int TRACE_LEN_MEM  = 22;
  localparam int TRACE_PKT_W    = TRACE_LEN_MEM * 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata;
`ifdef RISCV_TRACE_MEM_EN
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
    logic            mem;
    logic            wrt;
`endif
    logic            rd_flag;
  } trace_rec_t;

  // Byte 0 of the result is the header; the serializer shifts it out LSB byte first.
  function automatic logic [TRACE_PKT_W-1:0] trace_pack(input trace_rec_t rec, input logic lost);
    logic            mem_present;
    logic            wrt;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
    logic [7:0]      hdr;
`ifdef RISCV_TRACE_MEM_EN
    mem_present = rec.mem;
    wrt         = rec.wrt;
    maddr       = rec.maddr;
    mdata       = rec.mdata;
`else
    mem_present = 1'b0;
    wrt         = 1'b0;
    maddr       = '0;
    mdata       = '0;
`endif
    hdr = TRACE_HDR_SYNC | {1'b0, mem_present, wrt, rec.rd_flag, lost, (rec.instr == '0), 2'b00};
    return {mdata, maddr, rec.rdata, {3'b000, rec.rd}, rec.instr, rec.pc, hdr};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO of trace records with first-word-fall-through head output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t din_i,
  output logic       full_o,
  output logic       empty_o,
  output trace_rec_t head_o
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/riscv_trace_streamer.sv
// Captures retired-instruction records and streams them as 14/22-byte packets on valid/ready.
// Define RISCV_TRACE_MEM_EN to store and send memory address/data for loads and stores.
module riscv_trace_streamer
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              update_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [4:0]        reg_addr_i,
  input  logic [XLEN-1:0]   reg_data_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              mem_wrt_i,
  input  logic              mem_read_i,
  output logic [7:0]        m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              halt_o,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [TRACE_PKT_W-1:0] pkt_q, pkt_d;
  logic [4:0]             idx_q, idx_d;
  logic [4:0]             len_q, len_d;
  logic                   halt_pkt_q, halt_pkt_d;
  logic                   lost_q, lost_d;
  logic                   halt_seen_q, halt_seen_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

  trace_rec_t rec_in;
  trace_rec_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push_req;
  logic       push_ok;
  logic       drop;
  logic       pop;
  logic       hs;
  logic       last_byte;

  always_comb begin
    rec_in         = '0;
    rec_in.pc      = pc_i;
    rec_in.instr   = instr_i;
    rec_in.rd      = reg_addr_i;
    rec_in.rdata   = reg_data_i;
`ifdef RISCV_TRACE_MEM_EN
    rec_in.maddr   = mem_addr_i;
    rec_in.mdata   = mem_data_i;
    rec_in.mem     = mem_wrt_i | mem_read_i;
    rec_in.wrt     = mem_wrt_i;
`endif
    rec_in.rd_flag = mem_read_i;
  end

`ifndef RISCV_TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{mem_addr_i, mem_data_i, mem_wrt_i};
`endif

  assign push_req  = update_i & en_i & ~halt_seen_q;
  assign hs        = (state_q == ST_SEND) & m_tready_i;
  assign last_byte = (idx_q == len_q - 5'd1);
  assign pop       = hs & last_byte;
  assign push_ok   = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_ok),
    .pop_i  (pop),
    .din_i  (rec_in),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    halt_pkt_d  = halt_pkt_q;
    lost_d      = lost_q;
    halt_seen_d = halt_seen_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pkt_d      = trace_pack(head, lost_q | drop);
        idx_d      = '0;
        halt_pkt_d = (head.instr == '0);
`ifdef RISCV_TRACE_MEM_EN
        len_d      = head.mem ? 5'(TRACE_LEN_MEM) : 5'(TRACE_LEN_BASE);
`else
        len_d      = 5'(TRACE_LEN_BASE);
`endif
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          pkt_d = pkt_q >> 8;
          idx_d = idx_q + 5'd1;
          if (idx_q == '0) begin
            lost_d = 1'b0;
          end
          if (last_byte) begin
            state_d = halt_pkt_q ? ST_HALTED : ST_IDLE;
          end
        end else if (drop && idx_q == '0) begin
          // Losses while the header waits for the sink are folded into its lost bit.
          pkt_d[3] = 1'b1;
        end
      end
      default: ;
    endcase

    if (drop) begin
      lost_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
    if (push_ok && instr_i == '0) begin
      halt_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pkt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      halt_pkt_q  <= 1'b0;
      lost_q      <= 1'b0;
      halt_seen_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      halt_pkt_q  <= halt_pkt_d;
      lost_q      <= lost_d;
      halt_seen_q <= halt_seen_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_tvalid_o = (state_q == ST_SEND);
  assign m_tdata_o  = m_tvalid_o ? pkt_q[7:0] : 8'h00;
  assign m_tlast_o  = m_tvalid_o & last_byte;
  assign drop_cnt_o = drop_cnt_q;
  assign halt_o     = (state_q == ST_HALTED);
  assign busy_o     = ~fifo_empty | (state_q == ST_LOAD) | (state_q == ST_SEND);

endmodule

// File: tb/tb_riscv_trace_streamer.sv
// Directed bench for riscv_trace_streamer: packet bytes, latency, backpressure, overflow and halt.
module tb_riscv_trace_streamer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        update_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_wrt_i;
  logic        mem_read_i;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        m_tlast_o;
  logic [7:0]  drop_cnt_o;
  logic        halt_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] pkt_buf [32];
  int pkt_n;
  logic [7:0] alu_exp [14] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                               8'h50, 8'h00, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00};

  always #5 clk_i = ~clk_i;

  riscv_trace_streamer #(
    .DEPTH (4),
    .DROP_W(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .update_i  (update_i),
    .pc_i      (pc_i),
    .instr_i   (instr_i),
    .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_wrt_i (mem_wrt_i),
    .mem_read_i(mem_read_i),
    .m_tdata_o (m_tdata_o),
    .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i),
    .m_tlast_o (m_tlast_o),
    .drop_cnt_o(drop_cnt_o),
    .halt_o    (halt_o),
    .busy_o    (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    en_i       = 1'b0;
    update_i   = 1'b0;
    pc_i       = '0;
    instr_i    = '0;
    reg_addr_i = '0;
    reg_data_i = '0;
    mem_addr_i = '0;
    mem_data_i = '0;
    mem_wrt_i  = 1'b0;
    mem_read_i = 1'b0;
    m_tready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    en_i  = 1'b1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic [31:0] maddr, input logic [31:0] mdata,
                        input logic wrt, input logic rdm);
    @(negedge clk_i);
    pc_i       = pc;
    instr_i    = instr;
    reg_addr_i = rd;
    reg_data_i = rdata;
    mem_addr_i = maddr;
    mem_data_i = mdata;
    mem_wrt_i  = wrt;
    mem_read_i = rdm;
    update_i   = 1'b1;
    @(posedge clk_i);
    #1;
    update_i = 1'b0;
    $display("retire pc=0x%0h instr=0x%0h", pc, instr);
  endtask

  // Collects one packet into pkt_buf; toggle=1 alternates tready every cycle.
  task automatic recv_packet(input bit toggle);
    int   cyc;
    bit   rdy;
    bit   stalled;
    bit   done;
    logic [7:0] stall_data;
    pkt_n = 0;
    rdy = 1'b1;
    stalled = 1'b0;
    done = 1'b0;
    cyc = 0;
    stall_data = '0;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      m_tready_i = rdy;
      if (m_tvalid_o) begin
        if (stalled) check_eq("stall_stable", {24'd0, m_tdata_o}, {24'd0, stall_data});
        if (rdy) begin
          pkt_buf[pkt_n] = m_tdata_o;
          pkt_n++;
          stalled = 1'b0;
          if (m_tlast_o) done = 1'b1;
        end else begin
          stalled = 1'b1;
          stall_data = m_tdata_o;
        end
      end
      if (toggle) rdy = ~rdy;
      cyc++;
    end
    if (!done) check_eq("pkt_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    m_tready_i = 1'b0;
    $display("packet len=%0d hdr=0x%0h", pkt_n, pkt_buf[0]);
  endtask

  initial begin
    int vcount;

    // Reset state
    do_reset();
    check_eq("rst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
    check_eq("rst_tlast", {31'd0, m_tlast_o}, 32'd0);
    check_eq("rst_tdata", {24'd0, m_tdata_o}, 32'd0);
    check_eq("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    check_eq("rst_halt", {31'd0, halt_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);

    // Single ALU op, latency N+2
    retire(32'h0, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("lat_n", {31'd0, m_tvalid_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("lat_n1", {31'd0, m_tvalid_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("lat_n2", {31'd0, m_tvalid_o}, 32'd1);
    check_eq("lat_hdr", {24'd0, m_tdata_o}, 32'h80);
    recv_packet(1'b0);
    check_eq("alu_len", pkt_n, 32'd14);
    for (int i = 0; i < 14; i++) check_eq($sformatf("alu_b%0d", i), {24'd0, pkt_buf[i]}, {24'd0, alu_exp[i]});

    // Backpressure: same record with tready toggling
    retire(32'h0, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    recv_packet(1'b1);
    check_eq("bp_len", pkt_n, 32'd14);
    for (int i = 0; i < 14; i++) check_eq($sformatf("bp_b%0d", i), {24'd0, pkt_buf[i]}, {24'd0, alu_exp[i]});

    // Store
    do_reset();
    retire(32'h8, 32'h0ab02023, 5'd0, 32'd0, 32'h100, 32'hab, 1'b1, 1'b0);
    recv_packet(1'b0);
`ifdef RISCV_TRACE_MEM_EN
    check_eq("st_hdr", {24'd0, pkt_buf[0]}, 32'hE0);
    check_eq("st_len", pkt_n, 32'd22);
    check_eq("st_b14", {24'd0, pkt_buf[14]}, 32'h00);
    check_eq("st_b15", {24'd0, pkt_buf[15]}, 32'h01);
    check_eq("st_b16", {24'd0, pkt_buf[16]}, 32'h00);
    check_eq("st_b17", {24'd0, pkt_buf[17]}, 32'h00);
    check_eq("st_b18", {24'd0, pkt_buf[18]}, 32'hAB);
`else
    check_eq("st_hdr", {24'd0, pkt_buf[0]}, 32'h80);
    check_eq("st_len", pkt_n, 32'd14);
`endif
    check_eq("st_pc0", {24'd0, pkt_buf[1]}, 32'h08);

    // Overflow: 6 updates into a 4-deep FIFO with the sink stalled
    do_reset();
    for (int i = 0; i < 6; i++) retire(i * 4, 32'h00100093, 5'd1, i, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("ovf_drop", {24'd0, drop_cnt_o}, 32'd2);
    check_eq("ovf_busy", {31'd0, busy_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      recv_packet(1'b0);
      check_eq($sformatf("ovf_hdr%0d", k), {24'd0, pkt_buf[0]}, (k == 0) ? 32'h88 : 32'h80);
      check_eq($sformatf("ovf_pc%0d", k), {24'd0, pkt_buf[1]}, k * 4);
    end
    repeat (10) @(posedge clk_i);
    #1;
    check_eq("ovf_no5th", {31'd0, m_tvalid_o}, 32'd0);
    check_eq("ovf_idle", {31'd0, busy_o}, 32'd0);
    check_eq("ovf_drop_end", {24'd0, drop_cnt_o}, 32'd2);

    // Halt record followed by updates that must be ignored
    do_reset();
    retire(32'h10, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    retire(32'h14, 32'h00000000, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) retire(32'h18 + i * 4, 32'h00100093, 5'd1, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
    recv_packet(1'b0);
    check_eq("halt_pre_hdr", {24'd0, pkt_buf[0]}, 32'h80);
    check_eq("halt_pre_flag", {31'd0, halt_o}, 32'd0);
    recv_packet(1'b0);
    check_eq("halt_hdr", {24'd0, pkt_buf[0]}, 32'h84);
    check_eq("halt_pc", {24'd0, pkt_buf[1]}, 32'h14);
    check_eq("halt_len", pkt_n, 32'd14);
    check_eq("halt_flag", {31'd0, halt_o}, 32'd1);
    vcount = 0;
    m_tready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (m_tvalid_o) vcount++;
    end
    m_tready_i = 1'b0;
    #1;
    check_eq("halt_no_more", vcount, 32'd0);
    check_eq("halt_drop", {24'd0, drop_cnt_o}, 32'd0);
    check_eq("halt_busy", {31'd0, busy_o}, 32'd0);
    check_eq("halt_sticky", {31'd0, halt_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
